gray_counter_ud: RTL

Parametrised up/down Gray-code counter that replaces the fixed 4-bit up-only Gray counter. It adds count enable, direction control, synchronous load, selectable wrap or saturate at the ends, and a one-cycle boundary flag. It also drives a registered binary view of the count. It feeds Gray pointers and sequence stamps to clock-domain-crossing logic, so `out` changes exactly one bit per counted step.

---
 rtl/gray_counter_ud.sv | 100 ++++++++++
 1 files changed

// File: rtl/gray_counter_ud.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : gray_counter_ud                                               |
// | Purpose  : Parametrised up/down Gray-code counter with count enable,     |
// |            direction control, synchronous Gray-coded load, wrap or       |
// |            saturate at the ends, and a one-cycle boundary flag. A        |
// |            registered binary view of the count is also provided.         |
// | Ports    : clk      - clock, rising edge                                 |
// |            rstn     - synchronous active-low reset                       |
// |            en       - count enable (one step per cycle)                  |
// |            up       - direction: 1 = up, 0 = down                        |
// |            load     - synchronous load strobe (beats en)                 |
// |            load_val - Gray-coded value to load                           |
// |            out      - registered Gray count                              |
// |            bin_out  - registered binary equivalent of out                |
// |            wrap     - registered boundary-hit flag                       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module gray_counter_ud #(
  parameter int WIDTH = 4,
  parameter bit WRAP  = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] bin_out,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] c_max  = '1;
  localparam logic [WIDTH-1:0] c_zero = '0;
  localparam logic [WIDTH-1:0] c_one  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_wrap;

  logic [WIDTH-1:0] w_load_bin;
  logic [WIDTH-1:0] w_bin_next;
  logic             w_wrap_next;

  // Gray-to-binary: each binary bit is the parity of the Gray bits at and
  // above its position.
  for (genvar i = 0; i < WIDTH; i++) begin : g_g2b
    assign w_load_bin[i] = ^load_val[WIDTH-1:i];
  end

  always_comb begin
    w_bin_next  = r_bin;
    w_wrap_next = 1'b0;
    if (load) begin
      w_bin_next = w_load_bin;
    end else if (en) begin
      if (up) begin
        if (r_bin == c_max) begin
          w_wrap_next = 1'b1;
          if (WRAP) begin
            w_bin_next = c_zero;
          end
        end else begin
          w_bin_next = r_bin + c_one;
        end
      end else begin
        if (r_bin == c_zero) begin
          w_wrap_next = 1'b1;
          if (WRAP) begin
            w_bin_next = c_max;
          end
        end else begin
          w_bin_next = r_bin - c_one;
        end
      end
    end
  end

  // Gray and binary views are both registered from the same next-state value,
  // so they are coherent in every cycle and no input reaches an output
  // combinationally.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_bin  <= c_zero;
      r_gray <= c_zero;
      r_wrap <= 1'b0;
    end else begin
      r_bin  <= w_bin_next;
      r_gray <= w_bin_next ^ (w_bin_next >> 1);
      r_wrap <= w_wrap_next;
    end
  end

  assign out     = r_gray;
  assign bin_out = r_bin;
  assign wrap    = r_wrap;

endmodule
`default_nettype wire
